// File: rtl/sram_resp_pkg.sv
// Shared types and constants for the SRAM responder.
// The fill-on-reset feature is enabled by defining SRAM_RESP_INIT_EN.
package sram_resp_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    READ_WAIT = 2'd1,
    WRITE_ACK = 2'd2,
    INIT      = 2'd3
  } state_t;

  localparam logic [15:0] INIT_WORD   = 16'h0000;
  localparam int          RD_LAT_MIN  = 1;
  localparam int          RD_LAT_MAX  = 4;

  // An address is in range when every bit above the array index is zero.
  function automatic logic addr_in_range(input logic [15:0] addr, input int depth_log2);
    return ((addr >> depth_log2) == 16'h0000);
  endfunction

endpackage

// File: rtl/sram_resp_array.sv
// Word storage for the SRAM responder: one synchronous write port,
// one combinational read port, no reset.
module sram_resp_array #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [0:(1 << ADDR_W)-1];

  // Synchronous write port
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/sram_responder.sv
// CPU-side SRAM responder with programmable read latency and sticky range error.
// Define SRAM_RESP_INIT_EN to fill the array with INIT_WORD after every reset.
module sram_responder
  import sram_resp_pkg::*;
#(
  parameter int DEPTH_LOG2   = 8,
  parameter int READ_LATENCY = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        OE,
  input  logic        WE,
  input  logic [15:0] ADDR,
  input  logic [15:0] Data_to_SRAM,
  output logic [15:0] Data_from_SRAM,
  output logic        Ready,
  output logic        Busy,
  output logic        Addr_err
);

  // Out-of-range latencies are clamped to the supported window.
  localparam int LAT_C = (READ_LATENCY < RD_LAT_MIN) ? RD_LAT_MIN :
                         (READ_LATENCY > RD_LAT_MAX) ? RD_LAT_MAX : READ_LATENCY;
  localparam logic [1:0] CNT_LOAD = 2'(LAT_C - 1);

`ifdef SRAM_RESP_INIT_EN
  localparam state_t RESET_STATE = INIT;
  localparam logic   BUSY_RESET  = 1'b1;
`else
  localparam state_t RESET_STATE = IDLE;
  localparam logic   BUSY_RESET  = 1'b0;
`endif

  state_t                r_state, w_state_nxt;
  logic [1:0]            r_cnt, w_cnt_nxt;
  logic [15:0]           r_addr, w_addr_nxt;
  logic [15:0]           r_data, w_data_nxt;
  logic                  r_ready, w_ready_nxt;
  logic                  r_busy, w_busy_nxt;
  logic                  r_addr_err, w_addr_err_nxt;
  logic                  w_mem_we;
  logic [DEPTH_LOG2-1:0] w_mem_waddr;
  logic [15:0]           w_mem_wdata;
  logic [15:0]           w_mem_rdata;
  logic                  w_addr_ok;
  logic                  w_latched_ok;

`ifdef SRAM_RESP_INIT_EN
  logic [DEPTH_LOG2-1:0] r_init_addr, w_init_addr_nxt;
`endif

  assign w_addr_ok    = addr_in_range(ADDR, DEPTH_LOG2);
  assign w_latched_ok = addr_in_range(r_addr, DEPTH_LOG2);

  sram_resp_array #(
    .ADDR_W (DEPTH_LOG2),
    .DATA_W (16)
  ) u_array (
    .i_clk   (Clk),
    .i_we    (w_mem_we),
    .i_waddr (w_mem_waddr),
    .i_wdata (w_mem_wdata),
    .i_raddr (r_addr[DEPTH_LOG2-1:0]),
    .o_rdata (w_mem_rdata)
  );

  // Next-state, array write port and next output values
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_addr_nxt     = r_addr;
    w_data_nxt     = r_data;
    w_ready_nxt    = 1'b0;
    w_addr_err_nxt = r_addr_err;
    w_mem_we       = 1'b0;
    w_mem_waddr    = ADDR[DEPTH_LOG2-1:0];
    w_mem_wdata    = Data_to_SRAM;
`ifdef SRAM_RESP_INIT_EN
    w_init_addr_nxt = r_init_addr;
`endif
    case (r_state)
      IDLE: begin
        if (!WE) begin
          // WE wins over OE; out-of-range writes are acknowledged but dropped
          w_mem_we       = w_addr_ok;
          w_addr_err_nxt = r_addr_err | ~w_addr_ok;
          w_ready_nxt    = 1'b1;
          w_state_nxt    = WRITE_ACK;
        end else if (!OE) begin
          w_addr_nxt  = ADDR;
          w_cnt_nxt   = CNT_LOAD;
          w_state_nxt = READ_WAIT;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      READ_WAIT: begin
        if (OE) begin
          w_state_nxt = IDLE;
        end else if (ADDR != r_addr) begin
          w_addr_nxt = ADDR;
          w_cnt_nxt  = CNT_LOAD;
        end else if (r_cnt == 2'd0) begin
          w_data_nxt     = w_latched_ok ? w_mem_rdata : 16'h0000;
          w_addr_err_nxt = r_addr_err | ~w_latched_ok;
          w_ready_nxt    = 1'b1;
          w_state_nxt    = IDLE;
        end else begin
          w_cnt_nxt = r_cnt - 2'd1;
        end
      end
      WRITE_ACK: begin
        w_state_nxt = IDLE;
      end
      INIT: begin
`ifdef SRAM_RESP_INIT_EN
        w_mem_we    = 1'b1;
        w_mem_waddr = r_init_addr;
        w_mem_wdata = INIT_WORD;
        if (r_init_addr == {DEPTH_LOG2{1'b1}}) begin
          w_state_nxt = IDLE;
        end else begin
          w_init_addr_nxt = r_init_addr + 1'b1;
        end
`else
        w_state_nxt = IDLE;
`endif
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
    w_busy_nxt = (w_state_nxt != IDLE);
  end

  // FSM and output registers; the array itself is never reset
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state    <= RESET_STATE;
      r_cnt      <= 2'd0;
      r_addr     <= 16'h0000;
      r_data     <= 16'h0000;
      r_ready    <= 1'b0;
      r_busy     <= BUSY_RESET;
      r_addr_err <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_addr     <= w_addr_nxt;
      r_data     <= w_data_nxt;
      r_ready    <= w_ready_nxt;
      r_busy     <= w_busy_nxt;
      r_addr_err <= w_addr_err_nxt;
    end
  end

`ifdef SRAM_RESP_INIT_EN
  // Fill pointer walks the array once after each reset
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_init_addr <= '0;
    end else begin
      r_init_addr <= w_init_addr_nxt;
    end
  end
`endif

  assign Data_from_SRAM = r_data;
  assign Ready          = r_ready;
  assign Busy           = r_busy;
  assign Addr_err       = r_addr_err;

endmodule

// File: tb/tb_sram_responder.sv
// Directed self-checking bench for sram_responder (DEPTH_LOG2=8, READ_LATENCY=2).
module tb_sram_responder;

  localparam int LAT = 2;

  logic        Clk;
  logic        Reset;
  logic        OE;
  logic        WE;
  logic [15:0] ADDR;
  logic [15:0] Data_to_SRAM;
  logic [15:0] Data_from_SRAM;
  logic        Ready;
  logic        Busy;
  logic        Addr_err;

  int n_cmp;
  int n_err;

  sram_responder #(
    .DEPTH_LOG2   (8),
    .READ_LATENCY (LAT)
  ) dut (
    .Clk            (Clk),
    .Reset          (Reset),
    .OE             (OE),
    .WE             (WE),
    .ADDR           (ADDR),
    .Data_to_SRAM   (Data_to_SRAM),
    .Data_from_SRAM (Data_from_SRAM),
    .Ready          (Ready),
    .Busy           (Busy),
    .Addr_err       (Addr_err)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_word(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one active edge and settle just after it.
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // With the fill option the array is walked once after reset.
  task automatic wait_init();
`ifdef SRAM_RESP_INIT_EN
    repeat (255) step();
    check_bit("init_busy_last", Busy, 1'b1);
    step();
    check_bit("init_done", Busy, 1'b0);
`endif
  endtask

  task automatic do_write(input string tag, input logic [15:0] a, input logic [15:0] d,
                          input logic [15:0] hold);
    WE = 1'b0; ADDR = a; Data_to_SRAM = d;
    step();
    check_bit({tag, "_ready"}, Ready, 1'b1);
    check_bit({tag, "_busy"}, Busy, 1'b1);
    check_word({tag, "_dhold"}, Data_from_SRAM, hold);
    WE = 1'b1; OE = 1'b1;
    step();
    check_bit({tag, "_ready_end"}, Ready, 1'b0);
    check_bit({tag, "_idle"}, Busy, 1'b0);
  endtask

  task automatic do_read(input string tag, input logic [15:0] a, input logic [15:0] exp);
    OE = 1'b0; ADDR = a;
    step();
    check_bit({tag, "_acc_busy"}, Busy, 1'b1);
    check_bit({tag, "_acc_ready"}, Ready, 1'b0);
    for (int i = 0; i < LAT - 1; i++) begin
      step();
      check_bit({tag, "_wait_ready"}, Ready, 1'b0);
    end
    step();
    check_bit({tag, "_ready"}, Ready, 1'b1);
    check_word({tag, "_data"}, Data_from_SRAM, exp);
    OE = 1'b1;
    step();
    check_bit({tag, "_ready_end"}, Ready, 1'b0);
    check_word({tag, "_data_hold"}, Data_from_SRAM, exp);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    Reset = 1'b1; OE = 1'b1; WE = 1'b1; ADDR = 16'h0000; Data_to_SRAM = 16'h0000;
    repeat (2) @(posedge Clk);
    #1;
    check_word("rst_data", Data_from_SRAM, 16'h0000);
    check_bit("rst_ready", Ready, 1'b0);
    check_bit("rst_err", Addr_err, 1'b0);
`ifdef SRAM_RESP_INIT_EN
    check_bit("rst_busy", Busy, 1'b1);
`else
    check_bit("rst_busy", Busy, 1'b0);
`endif
    Reset = 1'b0;
    wait_init();

    // Write then read back at the nominal latency
    do_write("wr10", 16'h0010, 16'hBEEF, 16'h0000);
    do_read("rd10", 16'h0010, 16'hBEEF);

    // Both enables low: the write wins and read data is untouched
    OE = 1'b0;
    do_write("both5", 16'h0005, 16'h1234, 16'hBEEF);
    check_word("both5_hold", Data_from_SRAM, 16'hBEEF);
    do_read("rd5", 16'h0005, 16'h1234);

    // Address change restarts the count
    do_write("wr3", 16'h0003, 16'h3333, 16'h1234);
    do_write("wr4", 16'h0004, 16'h4444, 16'h1234);
    OE = 1'b0; ADDR = 16'h0003;
    step();
    ADDR = 16'h0004;
    step();
    check_bit("chg_e1_ready", Ready, 1'b0);
    step();
    check_bit("chg_e2_ready", Ready, 1'b0);
    check_word("chg_e2_data", Data_from_SRAM, 16'h1234);
    step();
    check_bit("chg_e3_ready", Ready, 1'b1);
    check_word("chg_e3_data", Data_from_SRAM, 16'h4444);
    OE = 1'b1;
    step();
    check_bit("chg_ready_end", Ready, 1'b0);

    // OE released mid-read aborts with no Ready and no data update
    OE = 1'b0; ADDR = 16'h0010;
    step();
    OE = 1'b1;
    step();
    check_bit("abort_busy", Busy, 1'b0);
    check_bit("abort_ready", Ready, 1'b0);
    step();
    check_bit("abort_ready2", Ready, 1'b0);
    check_word("abort_data", Data_from_SRAM, 16'h4444);

    // Out-of-range write is dropped, out-of-range read returns zero
    do_write("wr0", 16'h0000, 16'h0A0A, 16'h4444);
    check_bit("err_clear", Addr_err, 1'b0);
    do_write("wr_oor", 16'h0100, 16'hDEAD, 16'h4444);
    check_bit("err_after_wr", Addr_err, 1'b1);
    do_read("rd0", 16'h0000, 16'h0A0A);
    do_read("rd_oor", 16'h0100, 16'h0000);
    check_bit("err_sticky", Addr_err, 1'b1);

    // Reset during a read: everything clears at once, no Ready follows
    OE = 1'b0; ADDR = 16'h0010;
    step();
    Reset = 1'b1;
    #1;
    check_word("mid_rst_data", Data_from_SRAM, 16'h0000);
    check_bit("mid_rst_ready", Ready, 1'b0);
    check_bit("mid_rst_err", Addr_err, 1'b0);
`ifdef SRAM_RESP_INIT_EN
    check_bit("mid_rst_busy", Busy, 1'b1);
`else
    check_bit("mid_rst_busy", Busy, 1'b0);
`endif
    OE = 1'b1;
    step();
    Reset = 1'b0;
`ifdef SRAM_RESP_INIT_EN
    wait_init();
    do_read("post_rst_rd", 16'h0010, 16'h0000);
`else
    for (int i = 0; i < 3; i++) begin
      step();
      check_bit("post_rst_ready", Ready, 1'b0);
    end
    do_read("post_rst_rd", 16'h0010, 16'hBEEF);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sram_responder.md
SRAM_RESPONDER -- requirements
Module: sram_responder

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 8; the memory holds 2**DEPTH_LOG2 16-bit words.
REQ-002 SHALL have parameter READ_LATENCY, default 2; cycles from read acceptance to Ready, legal range 1..4.
REQ-003 SHALL have port Clk, input, 1 bit; the single clock, rising edge.
REQ-004 SHALL have port Reset, input, 1 bit; asynchronous, active-high.
REQ-005 SHALL have port OE, input, 1 bit; active-low output enable from the CPU side.
REQ-006 SHALL have port WE, input, 1 bit; active-low write enable from the CPU side.
REQ-007 SHALL have port ADDR, input, 16 bits; word address (MAR).
REQ-008 SHALL have port Data_to_SRAM, input, 16 bits; write data.
REQ-009 SHALL have port Data_from_SRAM, output, 16 bits; read data, registered.
REQ-010 SHALL have port Ready, output, 1 bit; one-cycle completion pulse for a read or write.
REQ-011 SHALL have port Busy, output, 1 bit; high while requests are not accepted.
REQ-012 SHALL have port Addr_err, output, 1 bit; sticky flag for any out-of-range access.

Function
REQ-013 FSM states SHALL be IDLE, READ_WAIT, WRITE_ACK and INIT; INIT exists only per REQ-027.
REQ-014 In IDLE with WE=0, the block SHALL write Data_to_SRAM to ADDR on that edge and go to WRITE_ACK.
REQ-015 WRITE_ACK SHALL pulse Ready for one cycle, then go to IDLE; a WE still low in IDLE SHALL write again, last value wins.
REQ-016 OE=0 and WE=0 together SHALL be treated as a write (WE priority).
REQ-017 In IDLE with OE=0 and WE=1, the block SHALL latch ADDR, load the counter with READ_LATENCY-1 and go to READ_WAIT.
REQ-018 When the READ_WAIT counter reaches 0:
- Data_from_SRAM SHALL load mem[latched addr] on that edge.
- Ready SHALL pulse for the following cycle.
- The FSM SHALL return to IDLE.
REQ-019 In READ_WAIT, if ADDR differs from the latched address, the block SHALL relatch it and restart the count.
REQ-020 In READ_WAIT, OE going high SHALL abort the read: no Ready, no data update, return to IDLE.
REQ-021 Data_from_SRAM SHALL hold its last read value until the next completed read; writes SHALL NOT change it.
REQ-022 Address range rules, where ADDR[15:DEPTH_LOG2] nonzero is out of range:
- Out-of-range reads SHALL return 16'h0000.
- Out-of-range writes SHALL be discarded.
- Both SHALL still complete with Ready and set Addr_err.
REQ-023 Busy SHALL be high in READ_WAIT, WRITE_ACK and INIT, and low in IDLE.

Reset
REQ-024 Reset SHALL asynchronously force the FSM to IDLE, or to INIT when REQ-027 applies.
REQ-025 Reset SHALL asynchronously clear Data_from_SRAM, Ready, Addr_err, the counter and the latched address to 0.
REQ-026 Reset mid-read or mid-write SHALL abort the operation with no Ready pulse; memory contents SHALL NOT be reset except by INIT.

Configuration
REQ-027 With SRAM_RESP_INIT_EN defined, after reset the FSM SHALL enter INIT and fill the memory with INIT_WORD:
- One address per cycle, starting at 0.
- Busy high and requests ignored during the fill.
- IDLE entered after 2**DEPTH_LOG2 cycles.
REQ-028 Without SRAM_RESP_INIT_EN, INIT logic SHALL be absent, the FSM SHALL leave reset in IDLE, and memory contents SHALL be undefined until written.

Structure
REQ-029 Package sram_resp_pkg SHALL hold the state enum type, the INIT_WORD constant (16'h0000) and the READ_LATENCY bounds.
REQ-030 The storage SHALL be a sub-module sram_resp_array: one synchronous write port, one read port, depth 2**DEPTH_LOG2, no reset.

Verification
REQ-031 Write then read: WE=0 with ADDR=16'h0010 and Data_to_SRAM=16'hBEEF, then OE=0 with ADDR=16'h0010 -> Ready 1 cycle after the write; Data_from_SRAM=16'hBEEF and Ready exactly 2 cycles after read acceptance (READ_LATENCY=2).
REQ-032 Simultaneous enables: OE=0 and WE=0 with ADDR=5 and data 16'h1234 -> write occurs; a later read of address 5 returns 16'h1234 and Data_from_SRAM is unchanged meanwhile.
REQ-033 Address change: ADDR changes from 3 to 4 one cycle into READ_WAIT -> count restarts; Ready arrives 2 cycles after the change with mem[4].
REQ-034 Out of range (DEPTH_LOG2=8): a write to ADDR=16'h0100 then a read of 16'h0100 -> read returns 16'h0000, Ready pulses for both, Addr_err=1 until Reset.
REQ-035 Reset mid-read: Reset asserted during READ_WAIT -> Ready never pulses, Data_from_SRAM=0 and FSM=IDLE immediately; with SRAM_RESP_INIT_EN, Busy stays high 256 cycles and any address then reads 16'h0000.
